moore_seq_driver: RTL and testbench
===================================

// Module: moore_seq_driver
// PURPOSE
//  Initiator/driver side of the serial x/y link into the 4-state Moore sequence detector
//  (x_in -> y_out). Accepts a parallel WIDTH-bit stimulus word and resets the detector via link_rstn.
//  Drives the word serially on x_out, MSB first, one bit per clock.
//  Captures the detector's y response after each bit and returns it as a parallel word with a done pulse.
//  Sits between a test/control sequencer and the detector; both share clk.
// PARAMETERS
//  WIDTH  8  stimulus/response word length in bits; legal range 2..32
// PORTS
//  clk        in   1      rising-edge clock, sole clock domain
//  rst        in   1      synchronous, active-high reset
//  start      in   1      request; accepted only when ready=1
//  data_in    in   WIDTH  stimulus word, sampled on the accepting edge
//  ready      out  1      1 only in IDLE
//  busy       out  1      1 in LINK_RST, SHIFT and TAIL
//  link_rstn  out  1      active-low reset to detector; 0 in LINK_RST and while rst=1
//  x_out      out  1      serial stimulus to detector x_in
//  y_in       in   1      detector y_out (Moore output)
//  resp_out   out  WIDTH  captured response, MSB = response to first bit
//  done       out  1      one-cycle pulse; resp_out valid from this cycle
// BEHAVIOUR
//  - Reset values: state=IDLE, ready=1, busy=0, link_rstn=0 during rst, x_out=0, resp_out=0, done=0.
//  - All outputs are decoded from registered state and datapath, with no y_in->output combinational path.
//  - FSM states:
//      IDLE     -> LINK_RST  when start && ready; on that edge, load shreg<=data_in, clear cap, bit counter<=0.
//      LINK_RST -> SHIFT     unconditionally (1 cycle; link_rstn=0, x_out=0).
//      SHIFT    -> TAIL      on the edge ending bit WIDTH-1; otherwise stay in SHIFT.
//      TAIL     -> DONE      unconditionally (x_out=0).
//      DONE     -> IDLE      unconditionally.
//  - SHIFT, cycle i (0..WIDTH-1): x_out=shreg[WIDTH-1]; shreg shifts left (zero fill) at the end of the cycle.
//  - Capture timing: y_in reflects the detector state after bit i in the cycle following bit i.
//    - On the edge ending SHIFT cycles 1..WIDTH-1, and on the edge ending TAIL: cap <= {cap[WIDTH-2:0], y_in}.
//    - y_in is never sampled in SHIFT cycle 0.
//  - DONE: on the edge entering DONE, resp_out <= the final cap value (the capture made on the edge ending TAIL).
//    done=1 for exactly the DONE cycle. resp_out is held until the next DONE or rst.
//  - Latency: accepting edge to done high = WIDTH+3 cycles (LINK_RST + WIDTH SHIFT + TAIL + DONE entry).
//    Next start can be accepted WIDTH+4 cycles after the previous one.
//  - start while ready=0 is ignored, with no queuing. data_in changes after acceptance have no effect.
//  - rst has priority over start in the same cycle.
//    rst mid-operation: next cycle state=IDLE, x_out=0, done=0, resp_out=0; the partial capture is discarded.
//  - Counter width is $clog2(WIDTH)+1; no wrap occurs within a transfer.
// TESTING
//  Bench instantiates this block looped to the 4-state detector (link_rstn->rstn, x_out->x_in, y_out->y_in).
//  Detector transitions:
//    a: x=0->b, x=1->c
//    b: x=0->c, x=1->d
//    c: x=0->b, x=1->d
//    d: x=0->c, x=1->a
//    y=1 in b and c.
//  1. rst=1 for 2 cycles, then 0 -> ready=1, busy=0, x_out=0, resp_out=8'h00, done=0, link_rstn=1 after release.
//  2. start with data_in=8'hFF -> link_rstn low for 1 cycle; x_out=1 for 8 cycles;
//     done 11 cycles after the accepting edge; resp_out=8'h92.
//  3. data_in=8'h00 -> resp_out=8'hFF. data_in=8'hAA -> resp_out=8'hD5. Run back-to-back; each starts from
//     detector state a regardless of the previous run.
//  4. Pulse start on every cycle while busy -> exactly one transfer; done pulses once; ready low WIDTH+3 cycles.
//  5. Assert rst during SHIFT bit 4 of a 8'hFF run -> next cycle IDLE, resp_out=0, no done;
//     a new 8'hAA run then yields 8'hD5.
//  6. WIDTH=2, data_in=2'b10 -> x_out sequence 1,0; resp_out=2'b11; done 5 cycles after acceptance.

Source files
------------

// File: rtl/moore_seq_driver.sv
// Serial stimulus driver for the x/y Moore detector link: resets the detector, shifts a word out
// MSB first and collects the per-bit y response into a parallel word; done 1 cycle, ready again after.
module moore_seq_driver #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] data_in,
  output logic             ready,
  output logic             busy,
  output logic             link_rstn,
  output logic             x_out,
  input  logic             y_in,
  output logic [WIDTH-1:0] resp_out,
  output logic             done
);

  localparam int CW   = $clog2(WIDTH) + 1;
  localparam int CAPW = WIDTH - 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LINK_RST,
    S_SHIFT,
    S_TAIL,
    S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  shreg_q, shreg_d;
  logic [CAPW-1:0]   cap_q,   cap_d;
  logic [WIDTH-1:0]  resp_q,  resp_d;
  logic [CW-1:0]     cnt_q,   cnt_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      shreg_q <= '0;
      cap_q   <= '0;
      resp_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cap_q   <= cap_d;
      resp_q  <= resp_d;
      cnt_q   <= cnt_d;
    end
  end

  // cap only needs WIDTH-1 bits: the last response arrives in TAIL and goes straight into resp.
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cap_d   = cap_q;
    resp_d  = resp_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_LINK_RST;
          shreg_d = data_in;
          cap_d   = '0;
          cnt_d   = '0;
        end
      end
      S_LINK_RST: begin
        state_d = S_SHIFT;
      end
      S_SHIFT: begin
        shreg_d = shreg_q << 1;
        cnt_d   = cnt_q + CW'(1);
        // y_in in bit 0 still shows the freshly reset detector, not a response.
        if (cnt_q != '0) begin
          cap_d = (cap_q << 1) | CAPW'(y_in);
        end
        if (cnt_q == LAST_BIT) begin
          state_d = S_TAIL;
        end
      end
      S_TAIL: begin
        resp_d  = {cap_q, y_in};
        state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign ready     = (state_q == S_IDLE);
  assign busy      = (state_q == S_LINK_RST) || (state_q == S_SHIFT) || (state_q == S_TAIL);
  assign link_rstn = !rst && (state_q != S_LINK_RST);
  assign x_out     = (state_q == S_SHIFT) && shreg_q[WIDTH-1];
  assign resp_out  = resp_q;
  assign done      = (state_q == S_DONE);

endmodule

// File: tb/tb_moore_seq_driver.sv
// Drives two driver instances (WIDTH 8 and 2), each looped to a behavioural 4-state detector.
module tb_moore_seq_driver;

  logic       clk;
  logic       rst;
  logic       start8, start2;
  logic [7:0] data8;
  logic [1:0] data2;
  logic       ready8, busy8, lrstn8, x8, y8, done8;
  logic [7:0] resp8;
  logic       ready2, busy2, lrstn2, x2, y2, done2;
  logic [1:0] resp2;
  logic [1:0] det8_q, det2_q;

  int errors = 0;
  int checks = 0;

  moore_seq_driver #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .data_in(data8),
    .ready(ready8), .busy(busy8), .link_rstn(lrstn8), .x_out(x8),
    .y_in(y8), .resp_out(resp8), .done(done8)
  );

  moore_seq_driver #(.WIDTH(2)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .data_in(data2),
    .ready(ready2), .busy(busy2), .link_rstn(lrstn2), .x_out(x2),
    .y_in(y2), .resp_out(resp2), .done(done2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Detector states a=0, b=1, c=2, d=3; y=1 in b and c.
  function automatic logic [1:0] det_next(input logic [1:0] s, input logic x);
    case (s)
      2'd0:    det_next = x ? 2'd2 : 2'd1;
      2'd1:    det_next = x ? 2'd3 : 2'd2;
      2'd2:    det_next = x ? 2'd3 : 2'd1;
      default: det_next = x ? 2'd0 : 2'd2;
    endcase
  endfunction

  always @(posedge clk) begin
    if (!lrstn8) det8_q <= 2'd0;
    else         det8_q <= det_next(det8_q, x8);
    if (!lrstn2) det2_q <= 2'd0;
    else         det2_q <= det_next(det2_q, x2);
  end

  assign y8 = (det8_q == 2'd1) || (det8_q == 2'd2);
  assign y2 = (det2_q == 2'd1) || (det2_q == 2'd2);

  // One 8-bit transfer observed for 12 cycles after the accepting edge (cycle 1 = first after it).
  // Returns with the driver back in IDLE, so an immediate next call is back-to-back.
  task automatic run8(input logic [7:0] d, input bit hold, output logic [7:0] resp,
                      output int lat, output logic [9:0] xw, output int lrst_lo,
                      output int rdy_lo, output int dcnt);
    resp = '0; lat = 0; xw = '0; lrst_lo = 0; rdy_lo = 0; dcnt = 0;
    start8 = 1'b1;
    data8  = d;
    @(posedge clk); #1;
    if (!hold) start8 = 1'b0;
    data8 = 8'($urandom);
    for (int k = 1; k <= 12; k++) begin
      if (k > 1) begin
        @(posedge clk); #1;
      end
      if (k <= 10) xw = {xw[8:0], x8};
      if (!lrstn8) lrst_lo++;
      if (!ready8) rdy_lo++;
      if (done8) begin
        dcnt++;
        if (lat == 0) begin
          lat  = k;
          resp = resp8;
        end
      end
    end
    start8 = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; start8 = 1'b0; start2 = 1'b0; data8 = '0; data2 = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (lrstn8 !== 1'b0) begin errors++; $display("FAIL rst_lrstn_low: got %b expected 0", lrstn8); end
    checks++; if (ready8 !== 1'b1) begin errors++; $display("FAIL rst_ready: got %b expected 1", ready8); end
    rst = 1'b0;
    @(posedge clk); #1;
    checks++; if (ready8 !== 1'b1) begin errors++; $display("FAIL post_rst_ready: got %b expected 1", ready8); end
    checks++; if (busy8 !== 1'b0) begin errors++; $display("FAIL post_rst_busy: got %b expected 0", busy8); end
    checks++; if (x8 !== 1'b0) begin errors++; $display("FAIL post_rst_x: got %b expected 0", x8); end
    checks++; if (resp8 !== 8'h00) begin errors++; $display("FAIL post_rst_resp: got %h expected 00", resp8); end
    checks++; if (done8 !== 1'b0) begin errors++; $display("FAIL post_rst_done: got %b expected 0", done8); end
    checks++; if (lrstn8 !== 1'b1) begin errors++; $display("FAIL post_rst_lrstn: got %b expected 1", lrstn8); end
    checks++; if (ready2 !== 1'b1) begin errors++; $display("FAIL post_rst_ready2: got %b expected 1", ready2); end
  endtask

  task automatic test_ones;
    logic [7:0] r; logic [9:0] xw; int lat, lr, rl, dc;
    run8(8'hFF, 1'b0, r, lat, xw, lr, rl, dc);
    checks++; if (r !== 8'h92) begin errors++; $display("FAIL ff_resp: got %h expected 92", r); end
    checks++; if (lat !== 11) begin errors++; $display("FAIL ff_latency: got %0d expected 11", lat); end
    checks++; if (xw !== 10'b0111111110) begin errors++; $display("FAIL ff_xseq: got %b expected 0111111110", xw); end
    checks++; if (lr !== 1) begin errors++; $display("FAIL ff_linkrst_cycles: got %0d expected 1", lr); end
    checks++; if (dc !== 1) begin errors++; $display("FAIL ff_done_count: got %0d expected 1", dc); end
    checks++; if (resp8 !== 8'h92) begin errors++; $display("FAIL ff_resp_held: got %h expected 92", resp8); end
    checks++; if (ready8 !== 1'b1) begin errors++; $display("FAIL ff_ready_after: got %b expected 1", ready8); end
  endtask

  task automatic test_back_to_back;
    logic [7:0] r; logic [9:0] xw; int lat, lr, rl, dc;
    run8(8'h00, 1'b0, r, lat, xw, lr, rl, dc);
    checks++; if (r !== 8'hFF) begin errors++; $display("FAIL b2b_00_resp: got %h expected ff", r); end
    checks++; if (xw !== 10'b0) begin errors++; $display("FAIL b2b_00_xseq: got %b expected 0000000000", xw); end
    checks++; if (lat !== 11) begin errors++; $display("FAIL b2b_00_latency: got %0d expected 11", lat); end
    run8(8'hAA, 1'b0, r, lat, xw, lr, rl, dc);
    checks++; if (r !== 8'hD5) begin errors++; $display("FAIL b2b_aa_resp: got %h expected d5", r); end
    checks++; if (xw !== 10'b0101010100) begin errors++; $display("FAIL b2b_aa_xseq: got %b expected 0101010100", xw); end
    checks++; if (lr !== 1) begin errors++; $display("FAIL b2b_aa_linkrst_cycles: got %0d expected 1", lr); end
    run8(8'hFF, 1'b0, r, lat, xw, lr, rl, dc);
    checks++; if (r !== 8'h92) begin errors++; $display("FAIL b2b_ff_resp: got %h expected 92", r); end
  endtask

  task automatic test_start_spam;
    logic [7:0] r; logic [9:0] xw; int lat, lr, rl, dc;
    run8(8'hAA, 1'b1, r, lat, xw, lr, rl, dc);
    checks++; if (dc !== 1) begin errors++; $display("FAIL spam_done_count: got %0d expected 1", dc); end
    checks++; if (rl !== 11) begin errors++; $display("FAIL spam_ready_low: got %0d expected 11", rl); end
    checks++; if (r !== 8'hD5) begin errors++; $display("FAIL spam_resp: got %h expected d5", r); end
    checks++; if (lr !== 1) begin errors++; $display("FAIL spam_linkrst_cycles: got %0d expected 1", lr); end
  endtask

  task automatic test_mid_reset;
    logic [7:0] r; logic [9:0] xw; int lat, lr, rl, dc, seen;
    start8 = 1'b1; data8 = 8'hFF;
    @(posedge clk); #1;
    start8 = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
    end
    checks++; if (busy8 !== 1'b1 || x8 !== 1'b1) begin errors++; $display("FAIL mid_bit4_shift: got busy=%b x=%b expected busy=1 x=1", busy8, x8); end
    rst = 1'b1;
    #1;
    checks++; if (lrstn8 !== 1'b0) begin errors++; $display("FAIL mid_rst_lrstn: got %b expected 0", lrstn8); end
    @(posedge clk); #1;
    rst = 1'b0;
    checks++; if (ready8 !== 1'b1) begin errors++; $display("FAIL mid_ready: got %b expected 1", ready8); end
    checks++; if (busy8 !== 1'b0) begin errors++; $display("FAIL mid_busy: got %b expected 0", busy8); end
    checks++; if (resp8 !== 8'h00) begin errors++; $display("FAIL mid_resp: got %h expected 00", resp8); end
    checks++; if (x8 !== 1'b0) begin errors++; $display("FAIL mid_x: got %b expected 0", x8); end
    seen = 0;
    for (int k = 0; k < 12; k++) begin
      if (done8) seen++;
      @(posedge clk); #1;
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL mid_no_done: got %0d pulses expected 0", seen); end
    run8(8'hAA, 1'b0, r, lat, xw, lr, rl, dc);
    checks++; if (r !== 8'hD5) begin errors++; $display("FAIL mid_rerun_resp: got %h expected d5", r); end
    checks++; if (lat !== 11) begin errors++; $display("FAIL mid_rerun_latency: got %0d expected 11", lat); end
  endtask

  task automatic test_width2;
    logic [3:0] xw; logic [1:0] r; int lat, dc;
    xw = '0; r = '0; lat = 0; dc = 0;
    start2 = 1'b1; data2 = 2'b10;
    @(posedge clk); #1;
    start2 = 1'b0; data2 = 2'b01;
    for (int k = 1; k <= 7; k++) begin
      if (k > 1) begin
        @(posedge clk); #1;
      end
      if (k <= 4) xw = {xw[2:0], x2};
      if (done2) begin
        dc++;
        if (lat == 0) begin
          lat = k;
          r   = resp2;
        end
      end
    end
    checks++; if (xw !== 4'b0100) begin errors++; $display("FAIL w2_xseq: got %b expected 0100", xw); end
    checks++; if (r !== 2'b11) begin errors++; $display("FAIL w2_resp: got %b expected 11", r); end
    checks++; if (lat !== 5) begin errors++; $display("FAIL w2_latency: got %0d expected 5", lat); end
    checks++; if (dc !== 1) begin errors++; $display("FAIL w2_done_count: got %0d expected 1", dc); end
  endtask

  initial begin
    test_reset;
    test_ones;
    test_back_to_back;
    test_start_spam;
    test_mid_reset;
    test_width2;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
